// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte-addressed word array behind a req/ready/done handshake
// with configurable wait states, sub-word load/store, extension and misalignment flag.
module data_mem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] alu_res,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic        done,
    output logic [31:0] out_data,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        m2r_q, m2r_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] out_data_q, out_data_d;
    logic        misalign_q, misalign_d;

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rdata;
    logic              mis_lat;
    logic              do_op;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] lane, input logic [1:0] sz);
        logic [31:0] w;
        w = old;
        case (sz)
            2'b00:   w[8*lane +: 8] = wd[7:0];
            2'b01:   w[16*lane[1] +: 16] = wd[15:0];
            2'b10:   w = wd;
            default: w = old;
        endcase
        return w;
    endfunction

    assign idx     = addr_q[ADDR_W+1:2];
    assign rdata   = mem[idx];
    assign mis_lat = is_misaligned(size_q, addr_q[1:0]);
    assign do_op   = (state_q == ACCESS) && (cnt_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        m2r_d      = m2r_q;
        size_d     = size_q;
        uns_d      = uns_q;
        out_data_d = out_data_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = alu_res;
                    wdata_d = write_data;
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    m2r_d   = mem_to_reg;
                    size_d  = size;
                    uns_d   = load_unsigned;
                    // Misaligned memory ops short-circuit straight to completion.
                    if (is_misaligned(size, alu_res[1:0]) && (mem_read || mem_write)) begin
                        state_d    = DONE;
                        out_data_d = mem_to_reg ? 32'd0 : alu_res;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = DONE;
                    misalign_d = mis_lat && (rd_q || wr_q);
                    if (!m2r_q)
                        out_data_d = addr_q;
                    else if (rd_q && !mis_lat)
                        out_data_d = load_ext(rdata, addr_q[1:0], size_q, uns_q);
                    else
                        out_data_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            out_data_q <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            misalign_q <= misalign_d;
        end
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rd_q    <= rd_d;
        wr_q    <= wr_d;
        m2r_q   <= m2r_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
    end

    // Array write shares the edge with the read above, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!reset && do_op && wr_q && !mis_lat)
            mem[idx] <= store_merge(rdata, wdata_q, addr_q[1:0], size_q);
    end

    assign ready    = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign out_data = out_data_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with hand-computed expectations.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] alu_res;
    logic [31:0] write_data;
    logic        ready;
    logic        done;
    logic [31:0] out_data;
    logic        misalign;

    int n_vec = 0;
    int n_err = 0;

    data_mem_ctrl #(.ADDR_W(10), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .req(req), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .size(size), .load_unsigned(load_unsigned),
        .alu_res(alu_res), .write_data(write_data), .ready(ready), .done(done),
        .out_data(out_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        req = 1'b1; mem_read = rd; mem_write = wr; mem_to_reg = m2r;
        size = sz; load_unsigned = uns; alu_res = addr; write_data = wd;
    endtask

    // Called just after a negedge while idle; returns after the cycle following done.
    task automatic op(input string tag, input logic rd, input logic wr, input logic m2r,
                      input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_out,
                      input logic exp_mis);
        int lat;
        chk({tag, ".ready"}, {31'd0, ready}, 32'd1);
        drive(rd, wr, m2r, sz, uns, addr, wd);
        @(posedge clk);
        #1 req = 1'b0; mem_read = 1'bx; mem_write = 1'bx; alu_res = 'x; write_data = 'x;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".out"}, out_data, exp_out);
        chk({tag, ".mis"}, {31'd0, misalign}, {31'd0, exp_mis});
        @(negedge clk);
        chk({tag, ".done1"}, {30'd0, done, ready}, 32'd1);
        chk({tag, ".hold"}, out_data, exp_out);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
        size = 2'b10; load_unsigned = 1'b0; alu_res = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst.ready", {31'd0, ready}, 32'd1);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.out", out_data, 32'd0);
        chk("rst.mis", {31'd0, misalign}, 32'd0);

        // Reset aborts a store still in ACCESS
        op("sw10a", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h1111_1111, 3, 32'h10, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h2222_2222);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort.ready", {31'd0, ready}, 32'd1);
        chk("abort.done", {31'd0, done}, 32'd0);
        op("lw10", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'h1111_1111, 1'b0);

        op("sw40", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 3, 32'h40, 1'b0);
        op("lw40", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        op("sb41", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0000_007F, 3, 32'h41, 1'b0);
        op("lb41", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h0, 3, 32'h0000_007F, 1'b0);
        op("lb43", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h43, 32'h0, 3, 32'hFFFF_FFDE, 1'b0);
        op("lbu43", 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h43, 32'h0, 3, 32'h0000_00DE, 1'b0);
        op("lh42", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h42, 32'h0, 3, 32'hFFFF_DEAD, 1'b0);
        op("lhu40", 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h40, 32'h0, 3, 32'h0000_7FEF, 1'b0);
        op("lw40b", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'hDEAD_7FEF, 1'b0);

        // Misaligned accesses
        op("sw42", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h42, 32'h1234_5678, 1, 32'h42, 1'b1);
        op("lw40c", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'hDEAD_7FEF, 1'b0);
        op("lh41", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h41, 32'h0, 1, 32'h0, 1'b1);
        op("sz11", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h40, 32'h0, 1, 32'h0, 1'b1);
        op("sh42", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0000_BEEF, 3, 32'h42, 1'b0);
        op("lw40d", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'hBEEF_7FEF, 1'b0);

        // ALU-only pass-through, with a stray req during ACCESS
        op("alu", 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 3, 32'h1234_5678, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'hCAFE_0000, 32'h0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("stray.done", {31'd0, done}, 32'd1);
        chk("stray.out", out_data, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray.idle", {30'd0, done, ready}, 32'd1);
        end

        // Address wrap and read-before-write
        op("swwrap", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'hA5A5_A5A5, 3, 32'h1000, 1'b0);
        op("lw0", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 3, 32'hA5A5_A5A5, 1'b0);
        op("rmw", 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h5A5A_5A5A, 3, 32'hA5A5_A5A5, 1'b0);
        op("lw0b", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 3, 32'h5A5A_5A5A, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
